// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the writeback slice.
//   ld_type_t  : load flavour carried from issue to completion (LB..LWR)
//   wb_state_t : writeback controller load-tracking state
//   REG_ZERO   : hard-wired zero register index (never written, never bypassed)
package mips_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LBU = 3'd1,
    LH  = 3'd2,
    LHU = 3'd3,
    LW  = 3'd4,
    LWL = 3'd5,
    LWR = 3'd6
  } ld_type_t;

  typedef enum logic {
    IDLE    = 1'b0,
    LD_WAIT = 1'b1
  } wb_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if: producer-side bus of the writeback controller.
//   ALU result channel : alu_valid/alu_ready, alu_reg, alu_data
//   Load issue channel : ld_valid/ld_ready, ld_reg, ld_type, ld_addr_lo, ld_old
//   Memory return      : mem_rvalid, mem_readdata
// Modports: master = pipeline/memory side, slave = writeback controller.
interface regfile_writeback_if;
  import mips_pkg::*;

  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;

  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_reg;
  ld_type_t    ld_type;
  logic [1:0]  ld_addr_lo;
  logic [31:0] ld_old;

  logic        mem_rvalid;
  logic [31:0] mem_readdata;

  modport master (
    output alu_valid, alu_reg, alu_data,
    output ld_valid, ld_reg, ld_type, ld_addr_lo, ld_old,
    output mem_rvalid, mem_readdata,
    input  alu_ready, ld_ready
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data,
    input  ld_valid, ld_reg, ld_type, ld_addr_lo, ld_old,
    input  mem_rvalid, mem_readdata,
    output alu_ready, ld_ready
  );

endinterface

// File: rtl/regfile_writeback_load_align.sv
// load_align: combinational load data alignment / extension / merge.
//   ld_type   in  ld_type_t  load flavour
//   addr_lo   in  2          effective address bits [1:0]
//   readdata  in  32         little-endian memory word
//   old       in  32         current rt value (LWL/LWR merge source)
//   result    out 32         value to write back
module load_align
  import mips_pkg::*;
(
  input  ld_type_t    ld_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] readdata,
  input  logic [31:0] old,
  output logic [31:0] result
);

  logic [31:0] byte_word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [4:0]  lwl_shift;
  logic [4:0]  lwr_shift;

  assign byte_word = readdata >> {addr_lo, 3'b000};
  assign byte_sel  = byte_word[7:0];
  assign half_sel  = addr_lo[1] ? readdata[31:16] : readdata[15:0];

  // LWL moves bytes [b:0] to the top of the register: shift left by 3-b bytes.
  // LWR moves bytes [3:b] to the bottom: shift right by b bytes.
  assign lwl_shift = {~addr_lo, 3'b000};
  assign lwr_shift = {addr_lo, 3'b000};

  always_comb begin
    result = readdata;
    case (ld_type)
      LB:  result = {{24{byte_sel[7]}}, byte_sel};
      LBU: result = {24'h000000, byte_sel};
      LH:  result = {{16{half_sel[15]}}, half_sel};
      LHU: result = {16'h0000, half_sel};
      LW:  result = readdata;
      LWL: result = (readdata << lwl_shift) | (old & ~(32'hFFFF_FFFF << lwl_shift));
      LWR: result = (readdata >> lwr_shift) | (old & ~(32'hFFFF_FFFF >> lwr_shift));
      default: result = readdata;
    endcase
  end

endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: serialises ALU results and one outstanding memory load
// onto the single register-file write port. A returning load owns the port;
// an ALU result accepted in that cycle waits in a one-entry buffer.
//   r_clk, reset (sync, active-high), r_clk_enable (low freezes everything)
//   wb            slave side of regfile_writeback_if (ALU/load/memory channels)
//   write_control/write_reg/write_data  registered regfile write port
//   busy          load outstanding or ALU buffer occupied
//   read_reg1/2, fwd_hit1/2, fwd_data1/2  write-port bypass
// Optional feature: define WB_BYPASS_EN to enable the bypass; otherwise the
// fwd_* outputs are tied to zero and read_reg1/2 are ignored.
module regfile_writeback
  import mips_pkg::*;
(
  input  logic        r_clk,
  input  logic        reset,
  input  logic        r_clk_enable,
  regfile_writeback_if.slave wb,
  output logic        write_control,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic        busy,
  input  logic [4:0]  read_reg1,
  input  logic [4:0]  read_reg2,
  output logic        fwd_hit1,
  output logic        fwd_hit2,
  output logic [31:0] fwd_data1,
  output logic [31:0] fwd_data2
);

  wb_state_t   state_reg, state_next;
  logic [4:0]  ld_reg_reg;
  ld_type_t    ld_type_reg;
  logic [1:0]  ld_addr_reg;
  logic [31:0] ld_old_reg;

  logic        buf_valid_reg, buf_valid_next;
  logic [4:0]  buf_reg_reg, buf_reg_next;
  logic [31:0] buf_data_reg, buf_data_next;

  logic        write_control_reg;
  logic [4:0]  write_reg_reg;
  logic [31:0] write_data_reg;

  logic        ld_accept, alu_accept, ld_done;
  logic        src_valid;
  logic [4:0]  src_reg;
  logic [31:0] src_data;
  logic [31:0] ld_result;

  load_align u_load_align (
    .ld_type  (ld_type_reg),
    .addr_lo  (ld_addr_reg),
    .readdata (wb.mem_readdata),
    .old      (ld_old_reg),
    .result   (ld_result)
  );

  assign wb.alu_ready = r_clk_enable && !buf_valid_reg;
  assign wb.ld_ready  = r_clk_enable && (state_reg == IDLE);
  assign ld_accept    = wb.ld_valid && wb.ld_ready;
  assign alu_accept   = wb.alu_valid && wb.alu_ready;
  assign ld_done      = r_clk_enable && (state_reg == LD_WAIT) && wb.mem_rvalid;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (ld_accept) state_next = LD_WAIT;
      LD_WAIT: if (ld_done)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Port priority: load completion, then buffered ALU, then direct ALU.
  // The buffer only fills in a load-return cycle, and the load FSM is back
  // in IDLE then, so it always drains before another load can return.
  always_comb begin
    src_valid      = 1'b0;
    src_reg        = REG_ZERO;
    src_data       = 32'h0;
    buf_valid_next = buf_valid_reg;
    buf_reg_next   = buf_reg_reg;
    buf_data_next  = buf_data_reg;
    if (ld_done) begin
      src_valid = 1'b1;
      src_reg   = ld_reg_reg;
      src_data  = ld_result;
      if (alu_accept) begin
        buf_valid_next = 1'b1;
        buf_reg_next   = wb.alu_reg;
        buf_data_next  = wb.alu_data;
      end
    end else if (buf_valid_reg) begin
      src_valid      = 1'b1;
      src_reg        = buf_reg_reg;
      src_data       = buf_data_reg;
      buf_valid_next = 1'b0;
    end else if (alu_accept) begin
      src_valid = 1'b1;
      src_reg   = wb.alu_reg;
      src_data  = wb.alu_data;
    end
  end

  always_ff @(posedge r_clk) begin
    if (reset) begin
      state_reg         <= IDLE;
      ld_reg_reg        <= REG_ZERO;
      ld_type_reg       <= LW;
      ld_addr_reg       <= 2'b00;
      ld_old_reg        <= 32'h0;
      buf_valid_reg     <= 1'b0;
      buf_reg_reg       <= REG_ZERO;
      buf_data_reg      <= 32'h0;
      write_control_reg <= 1'b0;
      write_reg_reg     <= REG_ZERO;
      write_data_reg    <= 32'h0;
    end else if (r_clk_enable) begin
      state_reg     <= state_next;
      buf_valid_reg <= buf_valid_next;
      buf_reg_reg   <= buf_reg_next;
      buf_data_reg  <= buf_data_next;
      if (ld_accept) begin
        ld_reg_reg  <= wb.ld_reg;
        ld_type_reg <= wb.ld_type;
        ld_addr_reg <= wb.ld_addr_lo;
        ld_old_reg  <= wb.ld_old;
      end
      // A $0 destination still uses the slot but never strobes the regfile.
      write_control_reg <= src_valid && (src_reg != REG_ZERO);
      if (src_valid) begin
        write_reg_reg  <= src_reg;
        write_data_reg <= src_data;
      end
    end
  end

  assign write_control = write_control_reg;
  assign write_reg     = write_reg_reg;
  assign write_data    = write_data_reg;
  assign busy          = (state_reg == LD_WAIT) || buf_valid_reg;

`ifdef WB_BYPASS_EN
  logic [1:0][4:0] rd_addr;
  logic [1:0]      hit;

  assign rd_addr[0] = read_reg1;
  assign rd_addr[1] = read_reg2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bypass
      assign hit[gi] = write_control_reg && (write_reg_reg == rd_addr[gi]) &&
                       (rd_addr[gi] != REG_ZERO);
    end
  endgenerate

  assign fwd_hit1  = hit[0];
  assign fwd_hit2  = hit[1];
  assign fwd_data1 = write_data_reg;
  assign fwd_data2 = write_data_reg;
`else
  logic unused_read_regs;
  assign unused_read_regs = ^{read_reg1, read_reg2};
  assign fwd_hit1  = 1'b0;
  assign fwd_hit2  = 1'b0;
  assign fwd_data1 = 32'h0;
  assign fwd_data2 = 32'h0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;
  import mips_pkg::*;

  logic        r_clk = 1'b0;
  logic        reset;
  logic        r_clk_enable;
  logic        write_control;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        busy;
  logic [4:0]  read_reg1, read_reg2;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;

  regfile_writeback_if wb_bus ();

  always #5 r_clk = ~r_clk;

  regfile_writeback dut (
    .r_clk         (r_clk),
    .reset         (reset),
    .r_clk_enable  (r_clk_enable),
    .wb            (wb_bus),
    .write_control (write_control),
    .write_reg     (write_reg),
    .write_data    (write_data),
    .busy          (busy),
    .read_reg1     (read_reg1),
    .read_reg2     (read_reg2),
    .fwd_hit1      (fwd_hit1),
    .fwd_hit2      (fwd_hit2),
    .fwd_data1     (fwd_data1),
    .fwd_data2     (fwd_data2)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Behavioural model: a queue of completed results in program order, one
  // popped onto the write port per enabled cycle, and a single load slot.
  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  wr_t         m_q[$];
  bit          m_ld_busy;
  logic [4:0]  m_ld_reg;
  ld_type_t    m_ld_type;
  logic [1:0]  m_ld_addr;
  logic [31:0] m_ld_old;
  logic        exp_wc;
  logic [4:0]  exp_wr;
  logic [31:0] exp_wd;
  logic        exp_busy;
  logic [31:0] model_rf[32];
  logic [31:0] dut_rf[32];

  function automatic logic [31:0] ref_align(input ld_type_t t, input logic [1:0] a,
                                            input logic [31:0] mem, input logic [31:0] old);
    logic [7:0] m[4];
    logic [7:0] r[4];
    int b;
    int h;
    b = int'(a);
    for (int i = 0; i < 4; i++) begin
      m[i] = mem[8*i +: 8];
      r[i] = old[8*i +: 8];
    end
    h = 2 * (b / 2);
    case (t)
      LB:  return {{24{m[b][7]}}, m[b]};
      LBU: return {24'h0, m[b]};
      LH:  return {{16{m[h+1][7]}}, m[h+1], m[h]};
      LHU: return {16'h0, m[h+1], m[h]};
      LWL: begin
        for (int i = 0; i <= b; i++) r[3-b+i] = m[i];
        return {r[3], r[2], r[1], r[0]};
      end
      LWR: begin
        for (int i = b; i < 4; i++) r[i-b] = m[i];
        return {r[3], r[2], r[1], r[0]};
      end
      default: return mem;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    reset                 = 1'b0;
    r_clk_enable          = 1'b1;
    wb_bus.alu_valid      = 1'b0;
    wb_bus.alu_reg        = 5'd0;
    wb_bus.alu_data       = 32'h0;
    wb_bus.ld_valid       = 1'b0;
    wb_bus.ld_reg         = 5'd0;
    wb_bus.ld_type        = LW;
    wb_bus.ld_addr_lo     = 2'b00;
    wb_bus.ld_old         = 32'h0;
    wb_bus.mem_rvalid     = 1'b0;
    wb_bus.mem_readdata   = 32'h0;
    read_reg1             = 5'd0;
    read_reg2             = 5'd0;
  endtask

  task automatic model_edge();
    bit ld_acc;
    bit alu_acc;
    wr_t w;
    if (reset) begin
      m_ld_busy = 1'b0;
      m_q.delete();
      exp_wc = 1'b0;
      exp_wr = 5'd0;
      exp_wd = 32'h0;
    end else if (r_clk_enable) begin
      ld_acc  = wb_bus.ld_valid && !m_ld_busy;
      alu_acc = wb_bus.alu_valid && (m_q.size() == 0);
      if (m_ld_busy && wb_bus.mem_rvalid) begin
        w.r = m_ld_reg;
        w.d = ref_align(m_ld_type, m_ld_addr, wb_bus.mem_readdata, m_ld_old);
        m_q.push_back(w);
        m_ld_busy = 1'b0;
      end else if (ld_acc) begin
        m_ld_reg  = wb_bus.ld_reg;
        m_ld_type = wb_bus.ld_type;
        m_ld_addr = wb_bus.ld_addr_lo;
        m_ld_old  = wb_bus.ld_old;
        m_ld_busy = 1'b1;
      end
      if (alu_acc) begin
        w.r = wb_bus.alu_reg;
        w.d = wb_bus.alu_data;
        m_q.push_back(w);
      end
      if (m_q.size() > 0) begin
        w = m_q.pop_front();
        exp_wc = (w.r != 5'd0);
        exp_wr = w.r;
        exp_wd = w.d;
        if (exp_wc) model_rf[w.r] = w.d;
      end else begin
        exp_wc = 1'b0;
      end
    end
    exp_busy = m_ld_busy || (m_q.size() > 0);
  endtask

  // One clock cycle: check ready outputs for the driven inputs, advance the
  // model, then check every registered output just after the edge.
  task automatic step();
    logic exp_alu_rdy;
    logic exp_ld_rdy;
    logic exp_h1;
    logic exp_h2;
    logic [31:0] exp_f;
    #1;
    exp_alu_rdy = r_clk_enable && (m_q.size() == 0);
    exp_ld_rdy  = r_clk_enable && !m_ld_busy;
    chk("alu_ready", {31'h0, wb_bus.alu_ready}, {31'h0, exp_alu_rdy});
    chk("ld_ready", {31'h0, wb_bus.ld_ready}, {31'h0, exp_ld_rdy});
    model_edge();
    @(posedge r_clk);
    #1;
    chk("write_control", {31'h0, write_control}, {31'h0, exp_wc});
    chk("write_reg", {27'h0, write_reg}, {27'h0, exp_wr});
    chk("write_data", write_data, exp_wd);
    chk("busy", {31'h0, busy}, {31'h0, exp_busy});
`ifdef WB_BYPASS_EN
    exp_h1 = exp_wc && (exp_wr == read_reg1) && (read_reg1 != 5'd0);
    exp_h2 = exp_wc && (exp_wr == read_reg2) && (read_reg2 != 5'd0);
    exp_f  = exp_wd;
`else
    exp_h1 = 1'b0;
    exp_h2 = 1'b0;
    exp_f  = 32'h0;
`endif
    chk("fwd_hit1", {31'h0, fwd_hit1}, {31'h0, exp_h1});
    chk("fwd_hit2", {31'h0, fwd_hit2}, {31'h0, exp_h2});
    chk("fwd_data1", fwd_data1, exp_f);
    chk("fwd_data2", fwd_data2, exp_f);
    if (write_control) begin
      dut_rf[write_reg] = write_data;
      $display("[TB] t=%0t write $%0d <= 0x%08h", $time, write_reg, write_data);
    end
  endtask

  task automatic do_load(input string name, input ld_type_t t, input logic [1:0] a,
                         input logic [31:0] old, input logic [31:0] mem,
                         input logic [31:0] lit);
    idle_inputs();
    wb_bus.ld_valid   = 1'b1;
    wb_bus.ld_reg     = 5'd3;
    wb_bus.ld_type    = t;
    wb_bus.ld_addr_lo = a;
    wb_bus.ld_old     = old;
    step();
    idle_inputs();
    wb_bus.mem_rvalid   = 1'b1;
    wb_bus.mem_readdata = mem;
    step();
    chk({name, "_data"}, write_data, lit);
    chk({name, "_wc"}, {31'h0, write_control}, 32'h1);
    idle_inputs();
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      model_rf[i] = 32'h0;
      dut_rf[i]   = 32'h0;
    end
    m_ld_busy = 1'b0;
    exp_wc = 1'b0;
    exp_wr = 5'd0;
    exp_wd = 32'h0;
    exp_busy = 1'b0;

    // Reset state
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    chk("rst_wc", {31'h0, write_control}, 32'h0);
    chk("rst_wr", {27'h0, write_reg}, 32'h0);
    chk("rst_wd", write_data, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    idle_inputs();
    step();

    // Single ALU write to $8, then read back the shadow regfile
    wb_bus.alu_valid = 1'b1;
    wb_bus.alu_reg   = 5'd8;
    wb_bus.alu_data  = 32'h1234_5678;
    step();
    chk("alu8_wc", {31'h0, write_control}, 32'h1);
    chk("alu8_wr", {27'h0, write_reg}, 32'h8);
    chk("alu8_wd", write_data, 32'h1234_5678);
    idle_inputs();
    step();
    chk("alu8_readback", dut_rf[8], 32'h1234_5678);

    // Load alignment cases
    do_load("lb",  LB,  2'd3, 32'h0,          32'h80FF_0000, 32'hFFFF_FF80);
    do_load("lbu", LBU, 2'd3, 32'h0,          32'h80FF_0000, 32'h0000_0080);
    do_load("lh",  LH,  2'd2, 32'h0,          32'h80FF_0000, 32'hFFFF_80FF);
    do_load("lwl", LWL, 2'd1, 32'hAABB_CCDD,  32'h1122_3344, 32'h3344_CCDD);
    do_load("lwr", LWR, 2'd1, 32'hAABB_CCDD,  32'h1122_3344, 32'hAA11_2233);

    // Load return and ALU result in the same cycle, both to $5
    wb_bus.ld_valid = 1'b1;
    wb_bus.ld_reg   = 5'd5;
    wb_bus.ld_type  = LW;
    step();
    idle_inputs();
    wb_bus.mem_rvalid   = 1'b1;
    wb_bus.mem_readdata = 32'hCAFE_F00D;
    wb_bus.alu_valid    = 1'b1;
    wb_bus.alu_reg      = 5'd5;
    wb_bus.alu_data     = 32'h0BAD_BEEF;
    read_reg1           = 5'd5;
    step();
    chk("same_ld_wd", write_data, 32'hCAFE_F00D);
    chk("same_ld_wr", {27'h0, write_reg}, 32'h5);
    chk("same_alu_rdy_low", {31'h0, wb_bus.alu_ready}, 32'h0);
    idle_inputs();
    step();
    chk("same_alu_wd", write_data, 32'h0BAD_BEEF);
    chk("same_alu_wc", {31'h0, write_control}, 32'h1);
    chk("same_alu_rdy_high", {31'h0, wb_bus.alu_ready}, 32'h1);
    chk("same_rf5", dut_rf[5], 32'h0BAD_BEEF);

    // ALU write to $0 never strobes the regfile
    wb_bus.alu_valid = 1'b1;
    wb_bus.alu_reg   = 5'd0;
    wb_bus.alu_data  = 32'hDEAD_0000;
    step();
    chk("r0_wc", {31'h0, write_control}, 32'h0);
    idle_inputs();

    // Reset while waiting for a load: the later return must be ignored
    wb_bus.ld_valid = 1'b1;
    wb_bus.ld_reg   = 5'd7;
    step();
    idle_inputs();
    reset = 1'b1;
    step();
    idle_inputs();
    wb_bus.mem_rvalid   = 1'b1;
    wb_bus.mem_readdata = 32'h7777_7777;
    step();
    chk("rst_ld_wc", {31'h0, write_control}, 32'h0);
    chk("rst_ld_busy", {31'h0, busy}, 32'h0);
    chk("rst_ld_ready", {31'h0, wb_bus.ld_ready}, 32'h1);
    idle_inputs();

`ifdef WB_BYPASS_EN
    // Bypass: pending write to $9 seen on read port 1, never on $0
    wb_bus.alu_valid = 1'b1;
    wb_bus.alu_reg   = 5'd9;
    wb_bus.alu_data  = 32'h9999_0009;
    read_reg1        = 5'd9;
    read_reg2        = 5'd0;
    step();
    chk("byp_hit1", {31'h0, fwd_hit1}, 32'h1);
    chk("byp_data1", fwd_data1, 32'h9999_0009);
    chk("byp_hit2", {31'h0, fwd_hit2}, 32'h0);
    idle_inputs();
`endif

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      reset                 = ($urandom_range(0, 99) < 2);
      r_clk_enable          = ($urandom_range(0, 9) != 0);
      wb_bus.alu_valid      = ($urandom_range(0, 99) < 60);
      wb_bus.alu_reg        = ($urandom_range(0, 3) == 0) ? 5'd5 : 5'($urandom_range(0, 31));
      wb_bus.alu_data       = $urandom;
      wb_bus.ld_valid       = ($urandom_range(0, 99) < 30);
      wb_bus.ld_reg         = ($urandom_range(0, 3) == 0) ? 5'd5 : 5'($urandom_range(0, 31));
      wb_bus.ld_type        = ld_type_t'(3'($urandom_range(0, 6)));
      wb_bus.ld_addr_lo     = 2'($urandom_range(0, 3));
      wb_bus.ld_old         = $urandom;
      wb_bus.mem_rvalid     = ($urandom_range(0, 99) < 40);
      wb_bus.mem_readdata   = $urandom;
      read_reg1             = ($urandom_range(0, 1) == 0) ? write_reg : 5'($urandom_range(0, 31));
      read_reg2             = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      step();
    end
    idle_inputs();
    step();
    step();

    // Regfile contents built from the DUT port vs. the model
    for (int i = 1; i < 32; i++) begin
      chk($sformatf("rf[%0d]", i), dut_rf[i], model_rf[i]);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
